// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce path.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'd0,
    RISE = 2'd1,
    HIGH = 2'd2,
    FALL = 2'd3
  } state_t;

  // Board-scale qualification window versus a short window for simulation.
  localparam int unsigned DEBOUNCE_CYCLES_BOARD = 1000000;
  localparam int unsigned DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input; all flops reset to 0.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      q_q <= '0;
    end else begin
      q_q <= {q_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = q_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Turns a raw bouncing button into a clean synchronous level via a
// synchroniser and a counter-qualified LOW/RISE/HIGH/FALL state machine.
module button_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic button_i,
  output logic button_o,
  output logic unstable_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_debounce: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  logic             sync;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (button_i),
    .q_o    (sync)
  );

  // Any sample opposite to the candidate level restarts qualification.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        LOW: begin
          if (sync) begin
            state_q <= RISE;
            cnt_q   <= CNT_W'(1);
          end
        end
        RISE: begin
          if (!sync) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!sync) begin
            state_q <= FALL;
            cnt_q   <= CNT_W'(1);
          end
        end
        FALL: begin
          if (sync) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Pure decode of the state register, so neither output can glitch.
  assign button_o   = (state_q == HIGH) || (state_q == FALL);
  assign unstable_o = (state_q == RISE) || (state_q == FALL);

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce against a run-length reference model.
module tb_button_debounce;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic clk;
  logic reset_n;
  logic btn;
  logic btn_o;
  logic unst;

  int checks;
  int errors;

  // Reference model: input delayed SYNC cycles; output flips once DEB
  // consecutive observed samples disagree with it.
  logic m_pipe [SYNC];
  logic m_out;
  int   m_run;

  button_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_n),
    .button_i  (btn),
    .button_o  (btn_o),
    .unstable_o(unst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_unstable();
    return m_run != 0;
  endfunction

  task automatic model_edge(input logic b, input logic r);
    logic s;
    if (!r) begin
      for (int i = 0; i < int'(SYNC); i++) m_pipe[i] = 1'b0;
      m_out = 1'b0;
      m_run = 0;
    end else begin
      s = m_pipe[SYNC-1];
      if (s == m_out) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == int'(DEB)) begin
          m_out = s;
          m_run = 0;
        end
      end
      for (int i = int'(SYNC) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = b;
    end
  endtask

  // One clock: drive inputs, advance model at the edge, settle 1 time unit.
  task automatic step(input logic b, input logic r);
    btn     = b;
    reset_n = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
  endtask

  task automatic test_reset();
    int rise_at;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (btn_o !== 1'b0 || unst !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got out=%b unst=%b exp out=0 unst=0", i, btn_o, unst);
      end
    end
    rise_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (btn_o !== m_out || unst !== m_unstable()) begin
        errors++;
        $display("FAIL reset_release cyc %0d got out=%b unst=%b exp out=%b unst=%b",
                 i, btn_o, unst, m_out, m_unstable());
      end
      if (btn_o === 1'b1 && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 6) begin
      errors++;
      $display("FAIL reset_latency got %0d exp 6", rise_at);
    end
  endtask

  task automatic test_press_release();
    int rise_at;
    int fall_at;
    int unst_cnt;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    rise_at  = 0;
    unst_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (btn_o !== m_out || unst !== m_unstable()) begin
        errors++;
        $display("FAIL press cyc %0d got out=%b unst=%b exp out=%b unst=%b",
                 i, btn_o, unst, m_out, m_unstable());
      end
      if (unst === 1'b1) unst_cnt++;
      if (btn_o === 1'b1 && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 6 || unst_cnt !== 3) begin
      errors++;
      $display("FAIL press_latency got rise=%0d unst_cycles=%0d exp rise=6 unst_cycles=3", rise_at, unst_cnt);
    end
    fall_at = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (btn_o !== m_out || unst !== m_unstable()) begin
        errors++;
        $display("FAIL release cyc %0d got out=%b unst=%b exp out=%b unst=%b",
                 i, btn_o, unst, m_out, m_unstable());
      end
      if (btn_o === 1'b0 && fall_at == 0) fall_at = i;
    end
    checks++;
    if (fall_at !== 6) begin
      errors++;
      $display("FAIL release_latency got %0d exp 6", fall_at);
    end
  endtask

  task automatic test_bounce();
    logic pat [4];
    int   unst_seen;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    unst_seen = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(pat[k], 1'b1);
        checks++;
        if (btn_o !== 1'b0 || unst !== m_unstable()) begin
          errors++;
          $display("FAIL bounce rep %0d idx %0d got out=%b unst=%b exp out=0 unst=%b",
                   r, k, btn_o, unst, m_unstable());
        end
        if (unst === 1'b1) unst_seen++;
      end
    end
    checks++;
    if (unst_seen == 0) begin
      errors++;
      $display("FAIL bounce_unstable got 0 unstable cycles exp >0");
    end
  endtask

  task automatic test_bounce_settle();
    logic pat [6];
    int   rise_at;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
    pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(pat[k], 1'b1);
      checks++;
      if (btn_o !== 1'b0 || unst !== m_unstable()) begin
        errors++;
        $display("FAIL settle_pattern idx %0d got out=%b unst=%b exp out=0 unst=%b",
                 k, btn_o, unst, m_unstable());
      end
    end
    rise_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      checks++;
      if (btn_o !== m_out || unst !== m_unstable()) begin
        errors++;
        $display("FAIL settle cyc %0d got out=%b unst=%b exp out=%b unst=%b",
                 i, btn_o, unst, m_out, m_unstable());
      end
      if (btn_o === 1'b1 && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 6 || btn_o !== 1'b1) begin
      errors++;
      $display("FAIL settle_latency got rise=%0d out=%b exp rise=6 out=1", rise_at, btn_o);
    end
  endtask

  task automatic test_release_bounce();
    logic pat [4];
    int   fall_at;
    int   falls;
    logic prev;
    pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    checks++;
    if (btn_o !== 1'b1) begin
      errors++;
      $display("FAIL rel_bounce_setup got out=%b exp 1", btn_o);
    end
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(pat[k], 1'b1);
        checks++;
        if (btn_o !== 1'b1 || unst !== m_unstable()) begin
          errors++;
          $display("FAIL rel_bounce rep %0d idx %0d got out=%b unst=%b exp out=1 unst=%b",
                   r, k, btn_o, unst, m_unstable());
        end
      end
    end
    fall_at = 0;
    falls   = 0;
    prev    = btn_o;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (btn_o !== prev) falls++;
      prev = btn_o;
      if (btn_o === 1'b0 && fall_at == 0) fall_at = i;
    end
    checks++;
    if (fall_at !== 6 || falls !== 1) begin
      errors++;
      $display("FAIL rel_bounce_fall got fall=%0d changes=%0d exp fall=6 changes=1", fall_at, falls);
    end
  endtask

  task automatic test_reset_mid();
    int rise_at;
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    checks++;
    if (unst !== 1'b1 || btn_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_qualify got out=%b unst=%b exp out=0 unst=1", btn_o, unst);
    end
    step(1'b1, 1'b0);
    checks++;
    if (unst !== 1'b0 || btn_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got out=%b unst=%b exp out=0 unst=0", btn_o, unst);
    end
    rise_at = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1);
      if (btn_o === 1'b1 && rise_at == 0) rise_at = i;
    end
    checks++;
    if (rise_at !== 6) begin
      errors++;
      $display("FAIL mid_restart_latency got %0d exp 6", rise_at);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int   len;
    logic r;
    step(1'b0, 1'b0);
    lvl = 1'b0;
    for (int burst = 0; burst < 150; burst++) begin
      lvl = ~lvl;
      len = int'($urandom_range(1, 7));
      r   = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < len; i++) begin
        step(lvl, (i == 0) ? r : 1'b1);
        checks++;
        if (btn_o !== m_out || unst !== m_unstable()) begin
          errors++;
          $display("FAIL random burst %0d cyc %0d got out=%b unst=%b exp out=%b unst=%b",
                   burst, i, btn_o, unst, m_out, m_unstable());
        end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    btn     = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < int'(SYNC); i++) m_pipe[i] = 1'b0;
    m_out = 1'b0;
    m_run = 0;
    #2;
    test_reset();
    test_press_release();
    test_bounce();
    test_bounce_settle();
    test_release_bounce();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
